// File: rtl/pipemem_io.sv
// MEM stage of the pipelined CPU: word-addressed data RAM, on-chip I/O registers and a
// stalling req/ack port to slow external I/O. Optional macro: PIPEMEM_IO_TIMEOUT_EN (external wait timeout).
module pipemem_io #(
    parameter int DADDR_W = 5,
    parameter int TIMEOUT = 64
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        mwmem,
    input  logic        mm2reg,
    input  logic [31:0] malu,
    input  logic [31:0] mb,
    output logic [31:0] mmo,
    output logic        mstall,
    output logic        io_req,
    output logic        io_we,
    output logic [3:0]  io_addr,
    output logic [31:0] io_wdata,
    input  logic [31:0] io_rdata,
    input  logic        io_ack,
    output logic [31:0] out_port0,
    output logic [31:0] out_port1,
    output logic [31:0] out_port2,
    input  logic [31:0] in_port0,
    input  logic [31:0] in_port1,
    output logic        io_err,
    output logic [1:0]  io_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t       state;
    state_t       state_next;
    logic [31:0]  ram [2**DADDR_W];
    logic [31:0]  rdbuf;
    logic [31:0]  in0_meta, in0_q, in1_meta, in1_q;
    logic [31:0]  rd_data;
    logic         ram_sel, reg_sel, ext_sel, ext_acc;
    logic         timeout_hit;
    logic         unused_bits;
    logic [DADDR_W-1:0] ram_idx;

    assign ram_sel  = ~malu[7];
    assign reg_sel  = (malu[7:6] == 2'b10);
    assign ext_sel  = (malu[7:6] == 2'b11);
    assign ext_acc  = (mwmem | mm2reg) & ext_sel;
    assign ram_idx  = malu[DADDR_W+1:2];
    assign io_addr  = malu[5:2];
    assign io_wdata = mb;
    assign io_state = state;

    // io_req rises on entry to WAIT and holds until the single-cycle io_ack is sampled;
    // io_we, io_addr and io_wdata are valid whenever io_req is high.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        mstall     = 1'b0;
        io_req     = 1'b0;
        io_we      = 1'b0;
        case (state)
            S_IDLE: begin
                // Stall in the same cycle the access is decoded, but never while held in reset.
                if (resetn && ext_acc) begin
                    mstall     = 1'b1;
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                mstall = 1'b1;
                io_req = 1'b1;
                io_we  = mwmem;
                if (io_ack || timeout_hit) state_next = S_DONE;
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rdbuf <= '0;
        end else if (state == S_WAIT) begin
            if (io_ack)           rdbuf <= io_rdata;
            else if (timeout_hit) rdbuf <= 32'hDEAD_BEEF;
        end
    end

`ifdef PIPEMEM_IO_TIMEOUT_EN
    logic [7:0] wait_cnt;
    logic       err_q;

    // Held at zero outside WAIT, so every WAIT visit starts counting from zero.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)              wait_cnt <= '0;
        else if (state != S_WAIT) wait_cnt <= '0;
        else                      wait_cnt <= wait_cnt + 8'd1;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) err_q <= 1'b0;
        else         err_q <= err_q | timeout_hit;
    end

    assign timeout_hit = (state == S_WAIT) && !io_ack && (wait_cnt == TIMEOUT_LAST);
    assign io_err      = err_q;
    assign unused_bits = ^{malu[31:8], malu[1:0]};
`else
    assign timeout_hit = 1'b0;
    assign io_err      = 1'b0;
    assign unused_bits = ^{malu[31:8], malu[1:0], TIMEOUT_LAST};
`endif

    always_ff @(posedge clock) begin
        if (mwmem && ram_sel && !mstall) ram[ram_idx] <= mb;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            out_port0 <= '0;
            out_port1 <= '0;
            out_port2 <= '0;
        end else if (mwmem && reg_sel && !mstall) begin
            case (malu[5:2])
                4'h0:    out_port0 <= mb;
                4'h1:    out_port1 <= mb;
                4'h2:    out_port2 <= mb;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            in0_meta <= '0;
            in0_q    <= '0;
            in1_meta <= '0;
            in1_q    <= '0;
        end else begin
            in0_meta <= in_port0;
            in0_q    <= in0_meta;
            in1_meta <= in_port1;
            in1_q    <= in1_meta;
        end
    end

    always_comb begin
        rd_data = '0;
        if (ram_sel) begin
            rd_data = ram[ram_idx];
        end else if (ext_sel) begin
            rd_data = rdbuf;
        end else begin
            case (malu[5:2])
                4'h0:    rd_data = out_port0;
                4'h1:    rd_data = out_port1;
                4'h2:    rd_data = out_port2;
                4'h3:    rd_data = in0_q;
                4'h4:    rd_data = in1_q;
                default: rd_data = '0;
            endcase
        end
    end

    assign mmo = mm2reg ? rd_data : malu;

endmodule

// File: tb/tb_pipemem_io.sv
// Directed self-checking bench for pipemem_io: RAM, I/O registers, input sync,
// external req/ack port, reset mid-access and (with PIPEMEM_IO_TIMEOUT_EN) the wait timeout.
module tb_pipemem_io;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        mwmem = 1'b0;
    logic        mm2reg = 1'b0;
    logic [31:0] malu = '0;
    logic [31:0] mb = '0;
    logic [31:0] mmo;
    logic        mstall;
    logic        io_req;
    logic        io_we;
    logic [3:0]  io_addr;
    logic [31:0] io_wdata;
    logic [31:0] io_rdata = '0;
    logic        io_ack = 1'b0;
    logic [31:0] out_port0, out_port1, out_port2;
    logic [31:0] in_port0 = '0;
    logic [31:0] in_port1 = '0;
    logic        io_err;
    logic [1:0]  io_state;

    int pass_cnt = 0;
    int check_cnt = 0;

    pipemem_io dut (
        .clock(clock), .resetn(resetn), .mwmem(mwmem), .mm2reg(mm2reg),
        .malu(malu), .mb(mb), .mmo(mmo), .mstall(mstall),
        .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
        .io_rdata(io_rdata), .io_ack(io_ack),
        .out_port0(out_port0), .out_port1(out_port1), .out_port2(out_port2),
        .in_port0(in_port0), .in_port1(in_port1), .io_err(io_err), .io_state(io_state)
    );

    always #5 clock = ~clock;

    // Driver: runs one external access; ack_delay = WAIT cycles without ack before the ack cycle, -1 = never.
    task automatic ext_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input int ack_delay,
                              output int stalls, output int rises, output logic [31:0] done_mmo,
                              output logic [3:0] seen_addr, output logic seen_we,
                              output logic [31:0] seen_wdata, output logic expired);
        logic prev_req;
        int   req_n;
        @(negedge clock);
        mwmem = we; mm2reg = !we; malu = addr; mb = wdata; io_ack = 1'b0;
        stalls = 0; rises = 0; req_n = 0; prev_req = 1'b0; expired = 1'b1;
        done_mmo = '0; seen_addr = '0; seen_we = 1'b0; seen_wdata = '0;
        for (int c = 0; c < 300; c++) begin
            #1;
            if (!mstall) begin
                done_mmo = mmo;
                expired = 1'b0;
                break;
            end
            stalls++;
            if (io_req && !prev_req) rises++;
            prev_req = io_req;
            if (io_req) begin
                req_n++;
                seen_addr = io_addr; seen_we = io_we; seen_wdata = io_wdata;
                if (ack_delay >= 0 && req_n == ack_delay + 1) begin
                    io_ack = 1'b1;
                    io_rdata = rdata;
                end
            end
            @(negedge clock);
            io_ack = 1'b0;
        end
        mwmem = 1'b0; mm2reg = 1'b0; malu = '0;
        @(negedge clock);
    endtask

    task automatic test_reset();
        resetn = 1'b0; malu = 32'h0000_1234;
        #12;
        check_cnt++; if (mmo !== 32'h0000_1234) $display("FAIL reset_mmo: got %h exp %h", mmo, 32'h1234); else pass_cnt++;
        check_cnt++; if ({mstall, io_req, io_we, io_err} !== 4'b0) $display("FAIL reset_ctl: got %b exp 0000", {mstall, io_req, io_we, io_err}); else pass_cnt++;
        check_cnt++; if ({out_port0, out_port1, out_port2} !== 96'd0) $display("FAIL reset_ports: got %h %h %h exp 0", out_port0, out_port1, out_port2); else pass_cnt++;
        check_cnt++; if (io_state !== 2'd0) $display("FAIL reset_state: got %0d exp 0", io_state); else pass_cnt++;
        mm2reg = 1'b1; malu = 32'h0000_00C0;
        #1;
        check_cnt++; if (mstall !== 1'b0) $display("FAIL reset_no_stall: got %b exp 0", mstall); else pass_cnt++;
        mm2reg = 1'b0; malu = '0;
        @(negedge clock);
        resetn = 1'b1;
    endtask

    task automatic test_ram();
        @(negedge clock);
        mwmem = 1'b1; malu = 32'h14; mb = 32'h1234_5678;
        #1;
        check_cnt++; if (mstall !== 1'b0) $display("FAIL ram_no_stall: got %b exp 0", mstall); else pass_cnt++;
        @(negedge clock);
        malu = 32'h18; mb = 32'hCAFE_0018;
        @(negedge clock);
        mwmem = 1'b0; mm2reg = 1'b1; malu = 32'h14;
        #1;
        check_cnt++; if (mmo !== 32'h1234_5678) $display("FAIL ram_load: got %h exp %h", mmo, 32'h1234_5678); else pass_cnt++;
        malu = 32'hFFFF_FF18;
        #1;
        check_cnt++; if (mmo !== 32'h0000_0000 + 32'hCAFE_0018 - 32'h0) begin
            // 0xFFFFFF18 has malu[7]=0, so it aliases RAM word 6
            $display("FAIL ram_alias: got %h exp %h", mmo, 32'hCAFE_0018);
        end else pass_cnt++;
        mm2reg = 1'b0; malu = 32'hABCD_0014;
        #1;
        check_cnt++; if (mmo !== 32'hABCD_0014) $display("FAIL alu_pass: got %h exp %h", mmo, 32'hABCD_0014); else pass_cnt++;
    endtask

    task automatic test_out_port();
        @(negedge clock);
        mwmem = 1'b1; malu = 32'h84; mb = 32'hA5;
        @(negedge clock);
        mwmem = 1'b0;
        check_cnt++; if (out_port1 !== 32'hA5) $display("FAIL out_port1: got %h exp %h", out_port1, 32'hA5); else pass_cnt++;
        check_cnt++; if ({out_port0, out_port2} !== 64'd0) $display("FAIL out_port_others: got %h %h exp 0", out_port0, out_port2); else pass_cnt++;
        mm2reg = 1'b1; malu = 32'h84;
        #1;
        check_cnt++; if (mmo !== 32'hA5) $display("FAIL out_port1_read: got %h exp %h", mmo, 32'hA5); else pass_cnt++;
        @(negedge clock);
        mm2reg = 1'b0; mwmem = 1'b1; malu = 32'h88; mb = 32'h77;
        @(negedge clock);
        mwmem = 1'b0; mm2reg = 1'b1;
        #1;
        check_cnt++; if (out_port2 !== 32'h77 || mmo !== 32'h77) $display("FAIL out_port2: got %h mmo %h exp 77", out_port2, mmo); else pass_cnt++;
        malu = 32'hA0;
        #1;
        check_cnt++; if (mmo !== 32'h0) $display("FAIL hole_read: got %h exp 0", mmo); else pass_cnt++;
        mm2reg = 1'b0;
    endtask

    task automatic test_in_sync();
        @(negedge clock);
        in_port0 = 32'h3C; in_port1 = 32'h99; mm2reg = 1'b1; malu = 32'h8C;
        #1;
        check_cnt++; if (mmo !== 32'h0) $display("FAIL in_sync_c0: got %h exp 0", mmo); else pass_cnt++;
        @(negedge clock);
        check_cnt++; if (mmo !== 32'h0) $display("FAIL in_sync_c1: got %h exp 0", mmo); else pass_cnt++;
        @(negedge clock);
        check_cnt++; if (mmo !== 32'h3C) $display("FAIL in_sync_c2: got %h exp %h", mmo, 32'h3C); else pass_cnt++;
        malu = 32'h90;
        #1;
        check_cnt++; if (mmo !== 32'h99) $display("FAIL in_port1_read: got %h exp %h", mmo, 32'h99); else pass_cnt++;
        mm2reg = 1'b0; mwmem = 1'b1; malu = 32'h8C; mb = 32'hFFFF_FFFF;
        @(negedge clock);
        mwmem = 1'b0; mm2reg = 1'b1;
        #1;
        check_cnt++; if (mmo !== 32'h3C || out_port0 !== 32'h0 || out_port1 !== 32'hA5 || out_port2 !== 32'h77)
            $display("FAIL in_port_store_ignored: mmo %h ports %h %h %h exp 3c 0 a5 77", mmo, out_port0, out_port1, out_port2);
        else pass_cnt++;
        mm2reg = 1'b0;
    endtask

    task automatic test_ext_read();
        int stalls, rises; logic [31:0] dmmo, swd; logic [3:0] sa; logic swe, to;
        ext_access(1'b0, 32'hC8, 32'h0, 32'h55, 3, stalls, rises, dmmo, sa, swe, swd, to);
        check_cnt++; if (to) $display("FAIL ext_read_bound: got expired exp done"); else pass_cnt++;
        check_cnt++; if (stalls != 5) $display("FAIL ext_read_stalls: got %0d exp 5", stalls); else pass_cnt++;
        check_cnt++; if (dmmo !== 32'h55) $display("FAIL ext_read_mmo: got %h exp %h", dmmo, 32'h55); else pass_cnt++;
        check_cnt++; if (sa !== 4'd2 || swe !== 1'b0) $display("FAIL ext_read_addr: got %0d we %b exp 2 0", sa, swe); else pass_cnt++;
        check_cnt++; if (rises != 1 || io_req !== 1'b0 || io_state !== 2'd0) $display("FAIL ext_read_once: rises %0d req %b state %0d exp 1 0 0", rises, io_req, io_state); else pass_cnt++;
    endtask

    task automatic test_ext_write();
        int stalls, rises; logic [31:0] dmmo, swd; logic [3:0] sa; logic swe, to;
        ext_access(1'b1, 32'hF0, 32'hCAFE, 32'h0, 0, stalls, rises, dmmo, sa, swe, swd, to);
        check_cnt++; if (to || stalls != 2) $display("FAIL ext_write_stalls: got %0d expired %b exp 2", stalls, to); else pass_cnt++;
        check_cnt++; if (sa !== 4'hC || swe !== 1'b1 || swd !== 32'hCAFE) $display("FAIL ext_write_bus: got %h %b %h exp c 1 cafe", sa, swe, swd); else pass_cnt++;
        check_cnt++; if (dmmo !== 32'hF0) $display("FAIL ext_write_mmo: got %h exp %h", dmmo, 32'hF0); else pass_cnt++;
        @(negedge clock);
        malu = 32'h10; io_ack = 1'b1;
        @(negedge clock);
        io_ack = 1'b0;
        check_cnt++; if (io_state !== 2'd0 || mstall !== 1'b0 || io_req !== 1'b0) $display("FAIL stray_ack: state %0d stall %b req %b exp 0 0 0", io_state, mstall, io_req); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int stalls, rises; logic [31:0] dmmo, swd; logic [3:0] sa; logic swe, to; bit seen;
        @(negedge clock);
        mwmem = 1'b1; malu = 32'h80; mb = 32'h11;
        @(negedge clock);
        mwmem = 1'b0; mm2reg = 1'b1; malu = 32'hC4;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            if (io_req) begin seen = 1; break; end
        end
        check_cnt++; if (!seen || out_port0 !== 32'h11) $display("FAIL reset_mid_setup: req %b port0 %h exp 1 11", seen, out_port0); else pass_cnt++;
        @(negedge clock);
        resetn = 1'b0;
        #1;
        check_cnt++; if (io_req !== 1'b0 || mstall !== 1'b0) $display("FAIL reset_mid_ctl: req %b stall %b exp 0 0", io_req, mstall); else pass_cnt++;
        check_cnt++; if (out_port0 !== 32'h0 || io_state !== 2'd0) $display("FAIL reset_mid_regs: port0 %h state %0d exp 0 0", out_port0, io_state); else pass_cnt++;
        mm2reg = 1'b0; malu = '0;
        @(negedge clock);
        resetn = 1'b1;
        ext_access(1'b0, 32'hC4, 32'h0, 32'h66, 0, stalls, rises, dmmo, sa, swe, swd, to);
        check_cnt++; if (to || stalls != 2 || dmmo !== 32'h66 || rises != 1)
            $display("FAIL reset_mid_after: stalls %0d mmo %h rises %0d exp 2 66 1", stalls, dmmo, rises);
        else pass_cnt++;
    endtask

`ifdef PIPEMEM_IO_TIMEOUT_EN
    task automatic test_timeout();
        int stalls, rises; logic [31:0] dmmo, swd; logic [3:0] sa; logic swe, to;
        ext_access(1'b0, 32'hD0, 32'h0, 32'h0, -1, stalls, rises, dmmo, sa, swe, swd, to);
        check_cnt++; if (to || stalls != 65) $display("FAIL timeout_stalls: got %0d exp 65", stalls); else pass_cnt++;
        check_cnt++; if (dmmo !== 32'hDEAD_BEEF) $display("FAIL timeout_mmo: got %h exp deadbeef", dmmo); else pass_cnt++;
        io_ack = 1'b1;
        @(negedge clock);
        io_ack = 1'b0;
        @(negedge clock);
        check_cnt++; if (io_err !== 1'b1 || io_state !== 2'd0) $display("FAIL timeout_sticky: err %b state %0d exp 1 0", io_err, io_state); else pass_cnt++;
        resetn = 1'b0;
        #1;
        check_cnt++; if (io_err !== 1'b0) $display("FAIL timeout_reset: got %b exp 0", io_err); else pass_cnt++;
        @(negedge clock);
        resetn = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_ram();
        test_out_port();
        test_in_sync();
        test_ext_read();
        test_ext_write();
        test_reset_mid();
`ifdef PIPEMEM_IO_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
